// File: rtl/ula_seq_pkg.sv
// Shared types, constants and negation helpers for the signed multiply/divide sequencer.
package ula_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_t;

  localparam logic       OP_MUL        = 1'b0;
  localparam logic       OP_DIV        = 1'b1;
  localparam int         ITER_COUNT    = 8;
  localparam logic [7:0] DIV_ZERO_QUOT = 8'hFF;

  function automatic logic [7:0] neg8(input logic [7:0] v);
    return ~v + 8'd1;
  endfunction

  function automatic logic [15:0] neg16(input logic [15:0] v);
    return ~v + 16'd1;
  endfunction

  // -128 maps to 8'h80, which reads correctly as unsigned 128.
  function automatic logic [7:0] abs8(input logic [7:0] v);
    return v[7] ? neg8(v) : v;
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// One iteration of unsigned shift-add multiply or restoring divide on a 17-bit accumulator.
module mul_div_step
  import ula_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         op,
  input  logic [2*W:0] acc,
  input  logic [W-1:0] mag_b,
  output logic [2*W:0] acc_next
);

  logic [W:0]   sum;
  logic [2*W:0] shifted;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    acc_next = acc;
    sum      = {1'b0, acc[2*W-1:W]};
    shifted  = {acc[2*W-1:0], 1'b0};
    if (op == OP_MUL) begin
      // Low half holds the remaining multiplier bits; the carry lands in the sum's top bit.
      if (acc[0]) sum = {1'b0, acc[2*W-1:W]} + {1'b0, mag_b};
      acc_next = {1'b0, sum, acc[W-1:1]};
    end else begin
      acc_next = shifted;
      if (shifted[2*W:W] >= {1'b0, mag_b})
        acc_next = {shifted[2*W:W] - {1'b0, mag_b}, shifted[W-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/signed_mul_div_sequencer.sv
// Multi-cycle signed 8x8 multiply / 8/8 divide controller with a start/done handshake.
module signed_mul_div_sequencer
  import ula_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit DONE_HOLD  = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    op,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] result,
  output logic                    div_by_zero,
  output logic                    overflow
);

  localparam int W = DATA_WIDTH;

  state_t       state, state_nxt;
  logic         op_q;
  logic [W-1:0] a_q, b_q;
  logic [W-1:0] mag_a, mag_b;
  logic         sign_a, sign_b;
  logic [2*W:0] acc, acc_nxt;
  logic [3:0]   cnt;
  logic         done_hold;
  logic         div_zero;
  logic         neg_res;
  logic         quo_ovf;
  logic [W-1:0] quo_fix, rem_fix;
  logic [2*W-1:0] prod_fix;

  assign sign_a   = a_q[W-1];
  assign sign_b   = b_q[W-1];
  assign mag_a    = abs8(a_q);
  assign mag_b    = abs8(b_q);
  assign div_zero = (op_q == OP_DIV) && (mag_b == '0);

  // Sign correction applied to the magnitude result in FIX.
  assign neg_res  = sign_a ^ sign_b;
  assign quo_ovf  = (acc[W-1:0] == 8'h80) && !neg_res;
  assign quo_fix  = neg_res ? neg8(acc[W-1:0]) : acc[W-1:0];
  assign rem_fix  = sign_a ? neg8(acc[2*W-1:W]) : acc[2*W-1:W];
  assign prod_fix = neg_res ? neg16(acc[2*W-1:0]) : acc[2*W-1:0];

  mul_div_step #(.W(W)) u_step (
    .op       (op_q),
    .acc      (acc),
    .mag_b    (mag_b),
    .acc_next (acc_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = PREP;
      PREP: state_nxt = div_zero ? FIX : ITER;
      ITER: if (cnt == 4'(ITER_COUNT - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == PREP) || (state == ITER) || (state == FIX);
    done = (state == DONE) || (DONE_HOLD && done_hold);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: non-blocking assignments so every register samples its pre-edge inputs.
      op_q        <= OP_MUL;
      a_q         <= '0;
      b_q         <= '0;
      acc         <= '0;
      cnt         <= '0;
      done_hold   <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          op_q        <= op;
          a_q         <= a;
          b_q         <= b;
          done_hold   <= 1'b0;
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
        end
        PREP: begin
          acc <= {{(W+1){1'b0}}, mag_a};
          cnt <= '0;
        end
        ITER: begin
          acc <= acc_nxt;
          cnt <= cnt + 4'd1;
        end
        FIX: begin
          if (div_zero) begin
            result      <= {a_q, DIV_ZERO_QUOT};
            div_by_zero <= 1'b1;
          end else if (op_q == OP_MUL) begin
            result <= prod_fix;
          end else begin
            result   <= {rem_fix, quo_fix};
            overflow <= quo_ovf;
          end
        end
        DONE: done_hold <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_mul_div_sequencer.sv
// Randomized self-checking bench: arithmetic reference model plus cycle-level timing scoreboard.
module tb_signed_mul_div_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;
  logic        busy, done, div_by_zero, overflow;
  logic [15:0] result;

  int checks = 0;
  int failures = 0;

  signed_mul_div_sequencer #(.DATA_WIDTH(8), .DONE_HOLD(1'b0)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: signed integer math, truncating division.
  task automatic ref_calc(input bit o, input logic [7:0] ia, input logic [7:0] ib,
                          output logic [15:0] r, output bit dz, output bit ov, output int lat);
    int sa, sb, q, rm;
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    dz = 1'b0; ov = 1'b0; lat = 11;
    if (!o) r = 16'(sa * sb);
    else if (sb == 0) begin r = {ia, 8'hFF}; dz = 1'b1; lat = 3; end
    else if (sa == -128 && sb == -1) begin r = 16'h0080; ov = 1'b1; end
    else begin q = sa / sb; rm = sa % sb; r = {8'(rm), 8'(q)}; end
  endtask

  // Timing model: k counts cycles since acceptance; done expected at k == m_lat.
  bit          active = 1'b0;
  int          k = 0;
  int          m_lat = 11;
  logic [15:0] m_result = 16'h0, p_result;
  bit          m_dbz = 1'b0, m_ovf = 1'b0, p_dbz, p_ovf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      active = 1'b0; k = 0; m_result = 16'h0; m_dbz = 1'b0; m_ovf = 1'b0;
    end else if (!active) begin
      if (start) begin
        ref_calc(op, a, b, p_result, p_dbz, p_ovf, m_lat);
        active = 1'b1; k = 1; m_dbz = 1'b0; m_ovf = 1'b0;
      end
    end else if (k == m_lat) begin
      active = 1'b0;
    end else begin
      k++;
      if (k == m_lat) begin m_result = p_result; m_dbz = p_dbz; m_ovf = p_ovf; end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("busy", 32'(busy), 32'(active && k < m_lat));
      check("done", 32'(done), 32'(active && k == m_lat));
      check("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (!(active && k < m_lat)) check("result", 32'(result), 32'(m_result));
    end
  end

  task automatic run_op(input string name, input bit o, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [15:0] er, input bit edz, input bit eov, input int elat);
    int n;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = o; a = ia; b = ib;
    @(negedge clk);
    start = 1'b0;
    n = 1; seen = 1'b0;
    while (!seen && n < 30) begin
      if (done) seen = 1'b1;
      else begin @(negedge clk); n++; end
    end
    check({name, "_latency"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(elat));
    check({name, "_result"}, 32'(result), 32'(er));
    check({name, "_dbz"}, 32'(div_by_zero), 32'(edz));
    check({name, "_ovf"}, 32'(overflow), 32'(eov));
  endtask

  function automatic logic [7:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 8'h80;
      1: return 8'hFF;
      2: return 8'h00;
      3: return 8'h7F;
      4: return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] r;
    bit dz, ov, o;
    int lat, dn;
    logic [7:0] ra, rb;

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_result", 32'(result), 32'h0);
    check("reset_flags", {30'h0, div_by_zero, overflow}, 32'h0);
    reset = 1'b0;

    // Pin the reference model to hand-worked values.
    ref_calc(1'b0, 8'h7F, 8'h80, r, dz, ov, lat);
    check("model_mul", 32'(r), 32'h0000_C080);
    ref_calc(1'b1, 8'hF9, 8'h02, r, dz, ov, lat);
    check("model_div", 32'(r), 32'h0000_FFFD);

    run_op("mul_7_m3",     1'b0, 8'h07, 8'hFD, 16'hFFEB, 1'b0, 1'b0, 11);
    run_op("mul_m128_m128",1'b0, 8'h80, 8'h80, 16'h4000, 1'b0, 1'b0, 11);
    run_op("mul_127_m128", 1'b0, 8'h7F, 8'h80, 16'hC080, 1'b0, 1'b0, 11);
    run_op("div_m7_2",     1'b1, 8'hF9, 8'h02, 16'hFFFD, 1'b0, 1'b0, 11);
    run_op("div_100_7",    1'b1, 8'h64, 8'h07, 16'h020E, 1'b0, 1'b0, 11);
    run_op("div_100_0",    1'b1, 8'h64, 8'h00, 16'h64FF, 1'b1, 1'b0, 3);
    run_op("div_m128_m1",  1'b1, 8'h80, 8'hFF, 16'h0080, 1'b0, 1'b1, 11);

    // start held high through an entire operation with operands churning.
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 8'h64; b = 8'h07;
    dn = 0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (done) dn++;
      op = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
    end
    start = 1'b0;
    check("spam_done_count", 32'(dn), 32'd1);
    check("spam_result", 32'(result), 32'h0000_020E);
    @(negedge clk);

    // Reset during the 4th ITER cycle, between clock edges.
    run_op("pre_reset", 1'b0, 8'h07, 8'hFD, 16'hFFEB, 1'b0, 1'b0, 11);
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 8'h55; b = 8'h33;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midreset_busy", 32'(busy), 32'h0);
    check("midreset_done", 32'(done), 32'h0);
    check("midreset_result", 32'(result), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    run_op("after_reset_3x5", 1'b0, 8'h03, 8'h05, 16'h000F, 1'b0, 1'b0, 11);

    for (int i = 0; i < 150; i++) begin
      o = 1'($urandom);
      ra = rand_operand();
      rb = rand_operand();
      ref_calc(o, ra, rb, r, dz, ov, lat);
      run_op("rand", o, ra, rb, r, dz, ov, lat);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
